// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Two-stage pipelined carry-lookahead adder/subtractor with a valid/ready
//   handshake. Sits between the ALU operand mux and the EX/MEM result path.
//   WIDTH must be a multiple of 8 (8..64). The adder is built from 8-bit
//   lookahead groups joined by a root lookahead over the group
//   generate/propagate terms.
//
//   Stage 1 registers the operand-conditioned g/p vectors, c0, and each
//   group's GOUT/POUT (the group's carry out and propagate, both taken with
//   a group carry-in of 0).
//   Stage 2 resolves the group carry-ins with the root lookahead, ripples
//   each group's bit carries from its true carry-in, and registers
//   sum/cout/ovf/zero.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operands presented
//   in_ready   block accepts operands this cycle (combinational from out_ready)
//   a, b       operands
//   sub        0: a+b+cin, 1: a-b (cin ignored)
//   cin        carry-in for add mode
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        result (modulo 2^WIDTH)
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
//   zero       sum == 0
//
// Build option
//   CLA_PIPE_SAT_EN: when defined, signed overflow saturates sum to the most
//   positive/negative value. ovf still reports 1, cout stays the unsaturated
//   carry, and zero is taken on the saturated value. When undefined, results
//   wrap and no saturation logic exists.

module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    logic             s2_adv;
    logic             s1_adv;

    // Stage-1 combinational terms
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g_n;
    logic [WIDTH-1:0] p_n;
    logic [NG-1:0]    gout_n;
    logic [NG-1:0]    pout_n;
    logic             c0_n;
    logic             gacc;
    logic             pacc;

    // Stage-1 registers
    logic             s1_valid;
    logic             s1_c0;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic [NG-1:0]    s1_gout;
    logic [NG-1:0]    s1_pout;

    // Stage-2 combinational terms
    logic [NG-1:0]    grp_c;
    logic [WIDTH-1:0] carry;
    logic             rc;
    logic [WIDTH-1:0] res;
    logic             ovf_n;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Group lookahead with carry-in 0: gacc ends as the group's carry out,
    // which is exactly the group generate GOUT.
    always_comb begin
        bx     = b ^ {WIDTH{sub}};
        c0_n   = sub | cin;
        g_n    = a & bx;
        p_n    = a ^ bx;
        gout_n = '0;
        pout_n = '0;
        gacc   = 1'b0;
        pacc   = 1'b1;
        for (int k = 0; k < NG; k++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gacc = g_n[k*GROUP+i] | (p_n[k*GROUP+i] & gacc);
                pacc = pacc & p_n[k*GROUP+i];
            end
            gout_n[k] = gacc;
            pout_n[k] = pacc;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_c0   <= c0_n;
            s1_g    <= g_n;
            s1_p    <= p_n;
            s1_gout <= gout_n;
            s1_pout <= pout_n;
        end
    end

    // Root lookahead gives each group's true carry-in; the bit carries are
    // then re-evaluated inside each group from that carry-in.
    always_comb begin
        grp_c    = '0;
        carry    = '0;
        rc       = 1'b0;
        grp_c[0] = s1_c0;
        for (int k = 1; k < NG; k++) begin
            grp_c[k] = s1_gout[k-1] | (s1_pout[k-1] & grp_c[k-1]);
        end
        for (int k = 0; k < NG; k++) begin
            rc = grp_c[k];
            for (int i = 0; i < GROUP; i++) begin
                rc = s1_g[k*GROUP+i] | (s1_p[k*GROUP+i] & rc);
                carry[k*GROUP+i] = rc;
            end
        end
        res   = s1_p ^ {carry[WIDTH-2:0], s1_c0};
        ovf_n = carry[WIDTH-1] ^ carry[WIDTH-2];
`ifdef CLA_PIPE_SAT_EN
        // On overflow both operands share a sign and p[MSB] is 0, so g[MSB]
        // equals the sign of a: 1 means negative overflow.
        if (ovf_n) begin
            res = s1_g[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    sum  <= res;
                    cout <= carry[WIDTH-1];
                    ovf  <= ovf_n;
                    zero <= ~|res;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;

    logic        v8_in, r8_in, v8_out, c8, o8, z8;
    logic [7:0]  a8, b8, s8;
    logic        v64_in, r64_in, v64_out, c64, o64, z64;
    logic [63:0] a64, b64, s64;

    int checks = 0;
    int errors = 0;

    cla_pipe_adder #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_pipe_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8_in), .in_ready(r8_in),
        .a(a8), .b(b8), .sub(1'b0), .cin(1'b0), .out_valid(v8_out),
        .out_ready(1'b1), .sum(s8), .cout(c8), .ovf(o8), .zero(z8)
    );

    cla_pipe_adder #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(v64_in), .in_ready(r64_in),
        .a(a64), .b(b64), .sub(1'b0), .cin(1'b0), .out_valid(v64_out),
        .out_ready(1'b1), .sum(s64), .cout(c64), .ovf(o64), .zero(z64)
    );

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sat32(input logic [31:0] s, input logic o, input logic amsb);
        if (SAT && o) return amsb ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s;
    endfunction

    function automatic logic [71:0] pack32(input logic [31:0] s, input logic c, input logic o);
        return 72'({s, c, o, (s == 32'h0)});
    endfunction

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic logic [71:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input logic ci);
        logic [31:0] yy;
        logic [32:0] r;
        logic        o;
        yy = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, yy} + {32'h0, (s | ci)};
        o  = (x[31] == yy[31]) && (r[31] != x[31]);
        return pack32(sat32(r[31:0], o, x[31]), r[32], o);
    endfunction

    // One isolated op: checks the 2-edge latency and the result.
    task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic ci, input logic [31:0] es,
                           input logic ec, input logic eo);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        sub       = s;
        cin       = ci;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 72'(out_valid), 72'(1'b0));
        tick();
        check({tag, "_valid"}, 72'(out_valid), 72'(1'b1));
        check(tag, 72'({sum, cout, ovf, zero}), pack32(sat32(es, eo, x[31]), ec, eo));
    endtask

    logic [31:0] got[$];
    logic [71:0] exp_q[$];
    logic [71:0] e;
    logic        fire;
    int          next_op;
    int          nout;

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        v8_in = 1'b0; a8 = '0; b8 = '0; v64_in = 1'b0; a64 = '0; b64 = '0;
        tick();
        tick();
        check("rst_valid", 72'(out_valid), 72'(1'b0));
        check("rst_data", 72'({sum, cout, ovf, zero}), 72'(0));
        check("rst_v8", 72'(v8_out), 72'(1'b0));
        reset = 1'b0;
        #1;
        check("rst_in_ready", 72'(in_ready), 72'(1'b1));

        // Width 8 and 64 instances
        v8_in = 1'b1; a8 = 8'h7F; b8 = 8'h01;
        v64_in = 1'b1; a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h1;
        tick();
        v8_in = 1'b0; v64_in = 1'b0;
        tick();
        check("w8_valid", 72'(v8_out), 72'(1'b1));
        check("w8_res", 72'({s8, c8, o8, z8}), 72'({(SAT ? 8'h7F : 8'h80), 1'b0, 1'b1, 1'b0}));
        check("w64_valid", 72'(v64_out), 72'(1'b1));
        check("w64_res", 72'({s64, c64, o64, z64}),
              72'({(SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000), 1'b0, 1'b1, 1'b0}));

        // Directed 32-bit vectors
        run_one("ripple_all", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        run_one("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_one("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("add_cin", 32'h1, 32'h1, 1'b0, 1'b1, 32'h3, 1'b0, 1'b0);
        run_one("sub_ign_cin", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
        run_one("sub_borrow", 32'd3, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_zero", 32'd5, 32'd5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        run_one("grp_carry", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
        run_one("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

        // Reset mid-operation
        in_valid = 1'b1; a = 32'd1; b = 32'd2; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
        tick();
        a = 32'd3; b = 32'd4; reset = 1'b1;
        tick();
        check("midrst_valid", 72'(out_valid), 72'(1'b0));
        check("midrst_sum", 72'(sum), 72'(0));
        reset = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_emit", 72'(out_valid), 72'(1'b0));
        end

        // Back-pressure: ops (i, i+1), consumer stalls for cycles 2..6
        next_op = 0;
        got.delete();
        for (int cyc = 0; cyc < 16; cyc++) begin
            out_ready = (cyc < 2 || cyc > 6);
            in_valid  = (next_op < 4);
            a         = 32'(next_op);
            b         = 32'(next_op + 1);
            sub       = 1'b0;
            cin       = 1'b0;
            #1;
            if (cyc >= 2 && cyc <= 6) begin
                check("bp_in_ready", 72'(in_ready), 72'(1'b0));
                check("bp_hold", 72'({out_valid, sum}), 72'({1'b1, 32'h1}));
            end
            if (out_valid && out_ready) got.push_back(sum);
            fire = in_valid && in_ready;
            tick();
            if (fire) next_op++;
        end
        check("bp_count", 72'(got.size()), 72'(4));
        for (int i = 0; i < 4; i++) begin
            check("bp_order", (i < got.size()) ? 72'(got[i]) : 72'bx, 72'(2 * i + 1));
        end

        // Full throughput with random operands
        exp_q.delete();
        nout = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 106; cyc++) begin
            if (cyc < 100) begin
                in_valid = 1'b1;
                a        = $urandom;
                b        = $urandom;
                sub      = 1'($urandom_range(0, 1));
                cin      = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) exp_q.push_back(model32(a, b, sub, cin));
            if (cyc >= 2 && cyc < 102) check("thru_valid", 72'(out_valid), 72'(1'b1));
            if (out_valid && out_ready) begin
                nout++;
                check("thru_nonempty", 72'(exp_q.size() != 0), 72'(1'b1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("thru_res", 72'({sum, cout, ovf, zero}), e);
                end
            end
            tick();
        end
        check("thru_count", 72'(nout), 72'(100));
        check("thru_drained", 72'(exp_q.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
